// File: rtl/result_serializer_pkg.sv
// Shared parameters, FSM state type and strobe bit positions for the
// result serializer and its tile buffer.
package result_serializer_pkg;

    localparam int DEF_S2P_SIZE    = 2;
    localparam int DEF_RESULT_SIZE = 16;
    localparam int DEF_TENSOR_SIZE = 4;
    localparam int DEF_TILE_CNT_W  = DEF_TENSOR_SIZE * 2 + 1;

    // Bit positions inside result_valid
    localparam int RV_WORD   = 0;
    localparam int RV_ACTIVE = 1;
    localparam int RV_FIRST  = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Word counter width; at least one bit even for a 1x1 tile.
    function automatic int word_cnt_w(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/result_serializer_tile_pingpong_buf.sv
// Two-entry ping-pong tile store: the array writes one entry while the
// serializer drains the other.
module tile_pingpong_buf
    import result_serializer_pkg::*;
#(
    parameter int TILE_W = 64
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              push,
    input  logic [TILE_W-1:0] push_data,
    input  logic              pop,
    output logic [TILE_W-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic [1:0]        count_next
);

    logic [TILE_W-1:0] entry_q [2];
    logic [TILE_W-1:0] entry_d [2];
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        count_q, count_d;
    logic              do_push, do_pop;

    assign do_push = push && (count_q != 2'd2);
    assign do_pop  = pop && (count_q != 2'd0);

    always_comb begin
        entry_d  = entry_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            entry_d[wr_ptr_q] = push_data;
            wr_ptr_d          = ~wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        // Simultaneous push and pop leave the occupancy unchanged
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Tile payload needs no reset: occupancy alone decides what is readable.
    always_ff @(posedge clk) begin
        entry_q <= entry_d;
    end

    assign rd_data    = entry_q[rd_ptr_q];
    assign full       = (count_q == 2'd2);
    assign empty      = (count_q == 2'd0);
    assign count_next = count_d;

endmodule

// File: rtl/result_serializer.sv
// Serializes GEMM result tiles into a one-word-per-cycle stream with
// write/active/first strobes and an end-of-convolution pulse.
module result_serializer
    import result_serializer_pkg::*;
#(
    parameter int S2P_SIZE    = DEF_S2P_SIZE,
    parameter int RESULT_SIZE = DEF_RESULT_SIZE,
    parameter int TILE_CNT_W  = DEF_TILE_CNT_W
) (
    input  logic                                  clk,
    input  logic                                  rstn,
    input  logic                                  start,
    input  logic [TILE_CNT_W-1:0]                 total_tiles,
    input  logic [S2P_SIZE*S2P_SIZE*RESULT_SIZE-1:0] acc_data,
    input  logic                                  acc_valid,
    output logic                                  acc_ready,
    output logic [RESULT_SIZE-1:0]                result,
    output logic [2:0]                            result_valid,
    output logic                                  conv_done
);

    localparam int TILE_WORDS = S2P_SIZE * S2P_SIZE;
    localparam int TILE_W     = TILE_WORDS * RESULT_SIZE;
    localparam int WORD_W     = word_cnt_w(TILE_WORDS);
    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(TILE_WORDS - 1);

    state_e                state_q, state_d;
    logic [TILE_CNT_W-1:0] total_q, total_d;
    logic [TILE_CNT_W-1:0] tiles_in_q, tiles_in_d;
    logic [TILE_CNT_W-1:0] tiles_out_q, tiles_out_d;
    logic [WORD_W-1:0]     word_q, word_d;
    logic                  acc_ready_q, acc_ready_d;
    logic [RESULT_SIZE-1:0] result_q, result_d;
    logic [2:0]            result_valid_q, result_valid_d;
    logic                  conv_done_q, conv_done_d;

    logic                  push, pop;
    logic                  buf_full, buf_empty;
    logic [1:0]            buf_count_next;
    logic [TILE_W-1:0]     rd_tile;

    assign push = acc_valid && acc_ready_q && !buf_full;

    tile_pingpong_buf #(
        .TILE_W (TILE_W)
    ) u_buf (
        .clk        (clk),
        .rstn       (rstn),
        .push       (push),
        .push_data  (acc_data),
        .pop        (pop),
        .rd_data    (rd_tile),
        .full       (buf_full),
        .empty      (buf_empty),
        .count_next (buf_count_next)
    );

    always_comb begin
        state_d        = state_q;
        total_d        = total_q;
        tiles_in_d     = tiles_in_q;
        tiles_out_d    = tiles_out_q;
        word_d         = word_q;
        result_d       = '0;
        result_valid_d = '0;
        conv_done_d    = 1'b0;
        pop            = 1'b0;

        if (push) begin
            tiles_in_d = tiles_in_q + TILE_CNT_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    total_d     = total_tiles;
                    tiles_in_d  = '0;
                    tiles_out_d = '0;
                    word_d      = '0;
                    state_d     = (total_tiles != '0) ? ST_RUN : ST_FLUSH;
                end
            end
            ST_RUN: begin
                if (tiles_out_q == total_q) begin
                    state_d = ST_FLUSH;
                end else if (!buf_empty) begin
                    result_d                 = rd_tile[int'(word_q)*RESULT_SIZE +: RESULT_SIZE];
                    result_valid_d[RV_WORD]   = 1'b1;
                    result_valid_d[RV_ACTIVE] = 1'b1;
                    result_valid_d[RV_FIRST]  = (word_q == '0);
                    // Freeing on the last word lets a buffered tile follow gaplessly
                    if (word_q == LAST_WORD) begin
                        word_d      = '0;
                        pop         = 1'b1;
                        tiles_out_d = tiles_out_q + TILE_CNT_W'(1);
                    end else begin
                        word_d = word_q + WORD_W'(1);
                    end
                end
            end
            ST_FLUSH: begin
                state_d     = ST_DONE;
                conv_done_d = 1'b1;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        acc_ready_d = (state_d == ST_RUN) && (buf_count_next != 2'd2) &&
                      (tiles_in_d < total_d);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q        <= ST_IDLE;
            total_q        <= '0;
            tiles_in_q     <= '0;
            tiles_out_q    <= '0;
            word_q         <= '0;
            acc_ready_q    <= 1'b0;
            result_q       <= '0;
            result_valid_q <= '0;
            conv_done_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            total_q        <= total_d;
            tiles_in_q     <= tiles_in_d;
            tiles_out_q    <= tiles_out_d;
            word_q         <= word_d;
            acc_ready_q    <= acc_ready_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            conv_done_q    <= conv_done_d;
        end
    end

    assign acc_ready    = acc_ready_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign conv_done    = conv_done_q;

endmodule

// File: tb/tb_result_serializer.sv
// Randomized self-checking bench for result_serializer against a
// transaction-level schedule model (tile start cycles, drain counts).
`timescale 1ns/1ps
module tb_result_serializer;

    localparam int S2P = 2;
    localparam int RS  = 16;
    localparam int TW  = S2P * S2P;
    localparam int TCW = 9;
    localparam int INF = 32'h7fff_ffff;

    logic              clk = 1'b0;
    logic              rstn;
    logic              start;
    logic [TCW-1:0]    total_tiles;
    logic [TW*RS-1:0]  acc_data;
    logic              acc_valid;
    logic              acc_ready;
    logic [RS-1:0]     result;
    logic [2:0]        result_valid;
    logic              conv_done;

    always #5 clk = ~clk;

    result_serializer #(
        .S2P_SIZE    (S2P),
        .RESULT_SIZE (RS),
        .TILE_CNT_W  (TCW)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .start        (start),
        .total_tiles  (total_tiles),
        .acc_data     (acc_data),
        .acc_valid    (acc_valid),
        .acc_ready    (acc_ready),
        .result       (result),
        .result_valid (result_valid),
        .conv_done    (conv_done)
    );

    typedef struct {
        logic [RS-1:0] word;
        bit            first;
        bit            last;
        int            cyc;
    } exp_t;

    exp_t exp_q[$];
    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    // Model: tiles wanted/accepted/drained, earliest free output slot,
    // expected conv_done cycle and first cycle a new start is honoured.
    int m_total = 0, m_acc = 0, m_drained = 0, m_next_free = 0;
    int m_done_cyc = -1, m_idle_from = 0, m_t0_last = -1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_total = 0; m_acc = 0; m_drained = 0; m_next_free = 0;
        m_done_cyc = -1; m_idle_from = 0; m_t0_last = -1;
    endtask

    // One clock: update the model at the edge, check outputs at the falling edge.
    task automatic step();
        bit              fire;
        bit              st;
        logic [TW*RS-1:0] d;
        logic [TCW-1:0]  tt;
        int              s;
        exp_t            e;
        bit              exp_rdy;
        fire = (rstn === 1'b1) && acc_valid && (acc_ready === 1'b1);
        st = start;
        d  = acc_data;
        tt = total_tiles;
        @(posedge clk);
        cyc++;
        if (rstn === 1'b1) begin
            if (fire) begin
                s = (cyc + 1 > m_next_free) ? cyc + 1 : m_next_free;
                m_next_free = s + TW;
                for (int w = 0; w < TW; w++) begin
                    e.word  = d[w*RS +: RS];
                    e.first = (w == 0);
                    e.last  = (w == TW - 1);
                    e.cyc   = s + w;
                    exp_q.push_back(e);
                end
                if (m_acc == 0) m_t0_last = s + TW - 1;
                m_acc++;
                if (m_acc == m_total) begin
                    m_done_cyc  = s + TW - 1 + 2;
                    m_idle_from = m_done_cyc + 2;
                end
            end
            if (st && cyc >= m_idle_from) begin
                m_total = int'(tt); m_acc = 0; m_drained = 0;
                m_next_free = 0; m_t0_last = -1;
                if (tt == '0) begin
                    m_done_cyc  = cyc + 1;
                    m_idle_from = m_done_cyc + 2;
                end else begin
                    m_done_cyc  = -1;
                    m_idle_from = INF;
                end
            end
        end
        @(negedge clk);
        if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
            e = exp_q.pop_front();
            chk("result", result, e.word);
            chk("result_valid", result_valid, e.first ? 3'd7 : 3'd3);
            if (e.last) m_drained++;
        end else begin
            chk("result_valid_idle", result_valid, 3'd0);
        end
        chk("conv_done", conv_done, cyc == m_done_cyc);
        exp_rdy = (m_acc < m_total) && (m_acc - m_drained < 2);
        chk("acc_ready", acc_ready, exp_rdy);
    endtask

    task automatic run_conv(input int total, input int vpct, input int gap,
                            input bit mid_start, input bit fixed);
        logic [TW*RS-1:0] tq[$];
        logic [TW*RS-1:0] t;
        int nxt = 0;
        int guard = 0;
        bit allow;
        for (int i = 0; i < total; i++) begin
            if (fixed) t = {16'h0044, 16'h0033, 16'h0022, 16'h0011};
            else       t = {$urandom, $urandom};
            tq.push_back(t);
        end
        start = 1'b1; total_tiles = TCW'(total); acc_valid = 1'b0;
        step();
        start = 1'b0;
        while (cyc + 1 < m_idle_from && guard < 300) begin
            allow = (nxt < total) && (int'($urandom_range(99)) < vpct) &&
                    (gap == 0 || nxt != 1 || (m_t0_last >= 0 && cyc >= m_t0_last + gap));
            acc_valid = allow;
            acc_data  = allow ? tq[nxt] : {$urandom, $urandom};
            start       = mid_start && (guard == 5);
            total_tiles = start ? TCW'(total + 3) : TCW'(total);
            if (allow && acc_ready === 1'b1) nxt++;
            step();
            guard++;
        end
        acc_valid = 1'b0;
        start = 1'b0;
        chk("conv_timeout", guard >= 300, 0);
        chk("accept_count", nxt, total);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        rstn = 1'b0; start = 1'b0; acc_valid = 1'b0;
        total_tiles = '0; acc_data = '0;
        step(); step();
        chk("reset_result", result, 0);
        chk("reset_result_valid", result_valid, 0);
        chk("reset_acc_ready", acc_ready, 0);
        chk("reset_conv_done", conv_done, 0);
        rstn = 1'b1;
        step();

        run_conv(1, 100, 0, 1'b0, 1'b1);   // single tile 11,22,33,44
        run_conv(3, 100, 0, 1'b0, 1'b0);   // back-to-back
        run_conv(2, 100, 6, 1'b0, 1'b0);   // starved input
        run_conv(0, 100, 0, 1'b0, 1'b0);   // empty convolution
        run_conv(3, 100, 0, 1'b1, 1'b0);   // start pulsed mid-RUN

        // Reset while word 2 of a tile is on the outputs
        start = 1'b1; total_tiles = TCW'(1);
        step();
        start = 1'b0;
        guard = 0;
        while (!(m_t0_last >= 0 && cyc == m_t0_last - 1) && guard < 50) begin
            acc_valid = (m_acc == 0);
            acc_data  = {16'h0044, 16'h0033, 16'h0022, 16'h0011};
            step();
            guard++;
        end
        chk("rst_scn_timeout", guard >= 50, 0);
        acc_valid = 1'b0;
        #2 rstn = 1'b0;
        #1;
        chk("midrst_result", result, 0);
        chk("midrst_result_valid", result_valid, 0);
        chk("midrst_acc_ready", acc_ready, 0);
        chk("midrst_conv_done", conv_done, 0);
        model_reset();
        step(); step();
        rstn = 1'b1;
        step();
        run_conv(1, 100, 0, 1'b0, 1'b1);

        for (int r = 0; r < 10; r++) begin
            run_conv(int'($urandom_range(1, 5)), int'($urandom_range(30, 100)), 0, 1'b0, 1'b0);
            repeat (int'($urandom_range(0, 3))) step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
